// File: rtl/sha3_squeeze_serializer.sv
// sha3_squeeze_serializer: captures SHA3 rate lanes 0..7 and streams the digest as 32-bit words.
// Define SHA3_SQUEEZE_BYTESWAP_EN to byte-reverse each emitted word (hex-digest byte order).
module sha3_squeeze_serializer #(
   parameter int DIGEST_BITS = 256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         state_valid,
   output logic         state_ready,
   input  logic [511:0] rate_lanes,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_data,
   output logic         out_last
);
   localparam int WORDS = DIGEST_BITS / 32;
   localparam int IDX_W = $clog2(WORDS);

   generate
      if (DIGEST_BITS != 224 && DIGEST_BITS != 256 &&
          DIGEST_BITS != 384 && DIGEST_BITS != 512) begin : g_bad_digest_bits
         $error("sha3_squeeze_serializer: DIGEST_BITS must be 224, 256, 384 or 512");
      end
   endgenerate

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   state_t                 state;
   logic [IDX_W-1:0]       idx;
   logic [WORDS-1:0][31:0] capture;
   logic                   last_word;
   logic                   fire;
   logic                   capture_en;
   logic [31:0]            sel_word;
   logic [31:0]            word;

   // Lanes above the digest length are deliberately dropped.
   logic unused_lanes;
   assign unused_lanes = ^rate_lanes;

   assign last_word   = (idx == IDX_W'(WORDS - 1));
   assign out_valid   = (state == EMIT) && !rst;
   assign fire        = out_valid && out_ready;
   assign state_ready = !rst && ((state == IDLE) || (fire && last_word));
   assign capture_en  = state_valid && state_ready;

   assign sel_word = capture[idx];
`ifdef SHA3_SQUEEZE_BYTESWAP_EN
   assign word = {sel_word[7:0], sel_word[15:8], sel_word[23:16], sel_word[31:24]};
`else
   assign word = sel_word;
`endif

   assign out_data = out_valid ? word : 32'h0;
   assign out_last = out_valid && last_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else if (capture_en) begin
         state <= EMIT;
         idx   <= '0;
      end else if (fire) begin
         if (last_word) begin
            state <= IDLE;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   // NOTE: the capture register is pure datapath and is not reset; out_valid gates every read of it.
   always_ff @(posedge clk) begin
      if (capture_en) begin
         capture <= rate_lanes[DIGEST_BITS-1:0];
      end
   end

endmodule

// File: tb/tb_sha3_squeeze_serializer.sv
// Self-checking bench: runs 256-, 224- and 512-bit instances on shared stimulus against a queue/position model.
module tb_sha3_squeeze_serializer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         state_valid = 1'b0;
   logic [511:0] rate_lanes = '0;
   logic         out_ready = 1'b1;

   logic        sr [3];
   logic        ov [3];
   logic        ol [3];
   logic [31:0] od [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sha3_squeeze_serializer #(.DIGEST_BITS(256)) u_dut (
      .clk(clk), .rst(rst), .state_valid(state_valid), .state_ready(sr[0]),
      .rate_lanes(rate_lanes), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od[0]), .out_last(ol[0]));

   sha3_squeeze_serializer #(.DIGEST_BITS(224)) u_d224 (
      .clk(clk), .rst(rst), .state_valid(state_valid), .state_ready(sr[1]),
      .rate_lanes(rate_lanes), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od[1]), .out_last(ol[1]));

   sha3_squeeze_serializer #(.DIGEST_BITS(512)) u_d512 (
      .clk(clk), .rst(rst), .state_valid(state_valid), .state_ready(sr[2]),
      .rate_lanes(rate_lanes), .out_valid(ov[2]), .out_ready(out_ready),
      .out_data(od[2]), .out_last(ol[2]));

   task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] at t=%0t: got %h want %h", name, k, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef SHA3_SQUEEZE_BYTESWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   // Word i of a digest built from the lane convention, lanes offset by base.
   function automatic logic [31:0] lit(input int i, input int base);
      logic [31:0] w;
      w = (i % 2 == 1) ? 32'hB000_0000 : 32'hA000_0000;
      w = w | 32'(base + i / 2);
      return fmt(w);
   endfunction

   function automatic logic [511:0] make_lanes(input int base);
      logic [511:0] l;
      for (int i = 0; i < 8; i++) begin
         l[64*i +: 64] = {32'hB000_0000 | 32'(base + i), 32'hA000_0000 | 32'(base + i)};
      end
      return l;
   endfunction

   // Model: captured lanes and the index of the word currently on the bus (-1 = no digest).
   int           wn [3] = '{8, 7, 16};
   logic [511:0] cap_m [3];
   int           pos [3] = '{-1, -1, -1};

   // Monitor state for directed checks.
   int          cyc = 0;
   logic [31:0] got0 [$];
   int          gcyc0 [$];
   int          lastcnt0 = 0;
   int          vcyc0 = 0;
   logic        last_sr0 = 1'b0;
   int          cnt [3] = '{0, 0, 0};
   logic [31:0] last_d [3];
   logic        prev_stall [3] = '{1'b0, 1'b0, 1'b0};
   logic [31:0] prev_od [3];

   always @(negedge clk) begin
      cyc++;
      for (int k = 0; k < 3; k++) begin
         logic        ev;
         logic        el;
         logic        er;
         logic [31:0] ed;
         ev = !rst && (pos[k] >= 0);
         el = ev && (pos[k] == wn[k] - 1);
         ed = ev ? fmt(cap_m[k][32*pos[k] +: 32]) : 32'h0;
         er = !rst && ((pos[k] < 0) || (el && out_ready));
         check("out_valid", k, 32'(ov[k]), 32'(ev));
         check("out_last", k, 32'(ol[k]), 32'(el));
         check("out_data", k, od[k], ed);
         check("state_ready", k, 32'(sr[k]), 32'(er));

         if (prev_stall[k] && ov[k]) check("stall_hold", k, od[k], prev_od[k]);
         prev_stall[k] = ov[k] && !out_ready;
         prev_od[k]    = od[k];

         if (ov[k] && out_ready) begin
            cnt[k]++;
            if (ol[k]) last_d[k] = od[k];
            if (k == 0) begin
               got0.push_back(od[0]);
               gcyc0.push_back(cyc);
               if (ol[0]) begin
                  lastcnt0++;
                  last_sr0 = sr[0];
               end
            end
         end
         if (k == 0 && ov[0]) vcyc0++;

         if (rst) begin
            pos[k] = -1;
         end else if (state_valid && er) begin
            cap_m[k] = rate_lanes;
            pos[k]   = 0;
         end else if (ev && out_ready) begin
            pos[k] = el ? -1 : pos[k] + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got0.delete();
      gcyc0.delete();
      lastcnt0 = 0;
      vcyc0    = 0;
      last_sr0 = 1'b0;
      for (int k = 0; k < 3; k++) cnt[k] = 0;
   endtask

   task automatic do_capture(input int base);
      rate_lanes  = make_lanes(base);
      state_valid = 1'b1;
      tick();
      state_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((pos[0] >= 0 || pos[1] >= 0 || pos[2] >= 0) && n < 300) begin
         tick();
         n++;
      end
      check("drain_timeout", 0, 32'(n < 300), 32'd1);
      tick();
   endtask

   localparam logic BP [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      int n;
      // Reset
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      #1;
      check("rst_ready", 0, 32'(sr[0]), 32'd0);
      check("rst_valid", 0, 32'(ov[0]), 32'd0);
      check("rst_data", 0, od[0], 32'h0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("post_rst_ready", 0, 32'(sr[0]), 32'd1);
      tick();

      // Basic digest on all three widths
      clear_mon();
      do_capture(0);
      drain();
      check("basic_count", 0, 32'(got0.size()), 32'd8);
      for (int i = 0; i < 8 && i < got0.size(); i++) check("basic_word", i, got0[i], lit(i, 0));
      if (gcyc0.size() == 8) check("basic_gapless", 0, 32'(gcyc0[7] - gcyc0[0]), 32'd7);
      check("basic_last_cnt", 0, 32'(lastcnt0), 32'd1);
      check("basic_last_ready", 0, 32'(last_sr0), 32'd1);
      check("d224_count", 1, 32'(cnt[1]), 32'd7);
      check("d224_last", 1, last_d[1], lit(6, 0));
      check("d512_count", 2, 32'(cnt[2]), 32'd16);
      check("d512_last", 2, last_d[2], lit(15, 0));

      // Backpressure: out_ready follows 1,0,0,1 from the first valid cycle
      clear_mon();
      do_capture(0);
      n = 0;
      while (got0.size() < 8 && n < 40) begin
         out_ready = BP[n % 4];
         tick();
         n++;
      end
      check("bp_timeout", 0, 32'(n < 40), 32'd1);
      out_ready = 1'b1;
      drain();
      check("bp_count", 0, 32'(got0.size()), 32'd8);
      for (int i = 0; i < 8 && i < got0.size(); i++) check("bp_word", i, got0[i], lit(i, 0));
      check("bp_cycles", 0, 32'(vcyc0), 32'd16);
      check("bp_last_cnt", 0, 32'(lastcnt0), 32'd1);

      // Back-to-back: second state offered while the first digest drains
      clear_mon();
      rate_lanes  = make_lanes(0);
      state_valid = 1'b1;
      tick();
      rate_lanes = make_lanes(16);
      repeat (8) tick();
      state_valid = 1'b0;
      drain();
      check("b2b_count", 0, 32'(got0.size()), 32'd16);
      if (got0.size() == 16) begin
         check("b2b_end1", 0, got0[7], lit(7, 0));
         check("b2b_start2", 0, got0[8], lit(0, 16));
         check("b2b_end2", 0, got0[15], lit(7, 16));
         check("b2b_no_gap", 0, 32'(gcyc0[8] - gcyc0[7]), 32'd1);
      end
      check("b2b_last_cnt", 0, 32'(lastcnt0), 32'd2);

      // Reset mid-digest after the third word
      clear_mon();
      do_capture(0);
      n = 0;
      while (got0.size() < 3 && n < 20) begin
         tick();
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("midrst_valid", 0, 32'(ov[0]), 32'd0);
      check("midrst_last", 0, 32'(ol[0]), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("midrst_words", 0, 32'(got0.size()), 32'd3);
      check("midrst_no_last", 0, 32'(lastcnt0), 32'd0);
      clear_mon();
      do_capture(0);
      drain();
      check("restart_count", 0, 32'(got0.size()), 32'd8);
      if (got0.size() > 0) check("restart_first", 0, got0[0], lit(0, 0));
      check("restart_last_cnt", 0, 32'(lastcnt0), 32'd1);

      // Reset and capture in the same cycle: reset wins
      clear_mon();
      rst         = 1'b1;
      rate_lanes  = make_lanes(32);
      state_valid = 1'b1;
      tick();
      rst         = 1'b0;
      state_valid = 1'b0;
      @(negedge clk);
      #1;
      check("rst_cap_valid", 0, 32'(ov[0]), 32'd0);
      repeat (4) tick();
      check("rst_cap_words", 0, 32'(got0.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
